// File: rtl/wb_stage.sv
// Writeback stage: EX/WB latch, architectural register file with bypassed
// combinational read ports, and a retired-instruction counter.

module wb_rd_port #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] arr_data,
  input  logic            byp_en,
  input  logic [AW-1:0]   byp_addr,
  input  logic [XLEN-1:0] byp_data,
  output logic [XLEN-1:0] data
);
  always_comb begin
    data = arr_data;
    if (addr == '0)                         data = '0;
    else if (byp_en && (byp_addr == addr))  data = byp_data;
  end
endmodule

module wb_stage #(
  parameter int XLEN    = 64,
  parameter int REG_NUM = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  input  logic [4:0]      ex_inst_type_i,
  input  logic            ex_rd_wen_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic [XLEN-1:0] ex_rd_data_i,
  input  logic            stall_i,
  input  logic [4:0]      rs1_r_addr,
  input  logic [4:0]      rs2_r_addr,
  output logic [XLEN-1:0] rs1_r_data,
  output logic [XLEN-1:0] rs2_r_data,
  output logic            wb_valid_o,
  output logic [4:0]      wb_inst_type_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic [XLEN-1:0] wb_rd_data_o,
  output logic [63:0]     retire_cnt_o
);
  localparam int NPORT = 2;

  logic                           wb_rd_wen;
  logic                           commit;
  logic                           wr_en;
  logic [REG_NUM-1:0][XLEN-1:0]   regs;
  logic [NPORT-1:0][4:0]          rd_addr;
  logic [NPORT-1:0][XLEN-1:0]     rd_data;

  assign commit = wb_valid_o & ~stall_i;
  // A committing write is only architecturally visible for nonzero targets.
  assign wr_en  = commit & wb_rd_wen & (wb_rd_addr_o != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_o     <= 1'b0;
      wb_inst_type_o <= '0;
      wb_rd_wen      <= 1'b0;
      wb_rd_addr_o   <= '0;
      wb_rd_data_o   <= '0;
    end else if (!stall_i) begin
      wb_valid_o     <= ex_valid_i;
      wb_inst_type_o <= ex_inst_type_i;
      wb_rd_wen      <= ex_rd_wen_i;
      wb_rd_addr_o   <= ex_rd_addr_i;
      wb_rd_data_o   <= ex_rd_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         regs <= '0;
    else if (wr_en)  regs[wb_rd_addr_o] <= wb_rd_data_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retire_cnt_o <= '0;
    else if (commit) retire_cnt_o <= retire_cnt_o + 64'd1;
  end

  assign rd_addr[0] = rs1_r_addr;
  assign rd_addr[1] = rs2_r_addr;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    wb_rd_port #(.XLEN(XLEN), .AW(5)) u_port (
      .addr     (rd_addr[p]),
      .arr_data (regs[rd_addr[p]]),
      .byp_en   (wr_en),
      .byp_addr (wb_rd_addr_o),
      .byp_data (wb_rd_data_o),
      .data     (rd_data[p])
    );
  end

  assign rs1_r_data = rd_data[0];
  assign rs2_r_data = rd_data[1];
endmodule
